// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serial bitstream loader for a configuration DFF chain.
// Optional readback CRC of the old chain contents enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 400,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rb_crc
);

  localparam int IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_n;
  // Holds only the bits not yet presented; bit 0 of each word goes straight to ccff_head.
  logic [WORD_W-2:0] shreg, shreg_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              head_n, en_n;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      idx          <= '0;
      ccff_head    <= 1'b0;
      chain_clk_en <= 1'b0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      idx          <= idx_n;
      ccff_head    <= head_n;
      chain_clk_en <= en_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    idx_n     = idx;
    head_n    = ccff_head;
    en_n      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = LOAD;
          bit_cnt_n = '0;
          idx_n     = '0;
        end
      end
      LOAD: begin
        if (bs_valid) begin
          shreg_n = bs_data[WORD_W-1:1];
          head_n  = bs_data[0];
          en_n    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        bit_cnt_n = bit_cnt + CNT_W'(1);
        idx_n     = idx + IDX_W'(1);
        if (bit_cnt == LAST_BIT) begin
          state_n = DONE;
        end else if (idx == LAST_IDX) begin
          state_n = LOAD;
          idx_n   = '0;
        end else begin
          head_n  = shreg[0];
          shreg_n = shreg >> 1;
          en_n    = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bs_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef CCFF_READBACK_EN
  logic crc_fb;
  assign crc_fb = rb_crc[15] ^ ccff_tail;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      rb_crc <= 16'h0000;
    end else if (state == IDLE && start) begin
      rb_crc <= 16'hFFFF;
    end else if (state == SHIFT) begin
      rb_crc <= {rb_crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rb_crc      = 16'h0000;
`endif

endmodule
